// File: rtl/ecc_scrub_pkg.sv
//------------------------------------------------------------------------------
// Module : ecc_scrub_pkg
// Brief  : Shared types and widths for the ECC scrub controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ecc_scrub_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CHECK   = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_NEXT    = 3'd5,
        ST_FIN     = 3'd6
    } scrub_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  chk;
    } ecc_word_t;

endpackage

`default_nettype wire

// File: rtl/ecc_scrub_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : ecc_scrub_ctrl_if
// Brief  : Memory port and SEC corrector port bundle for the scrub controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ecc_scrub_ctrl_if #(
    parameter int AW = 10
);
    import ecc_scrub_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [CHK_W-1:0]  mem_rchk;
    logic [DATA_W-1:0] mem_wdata;
    logic [CHK_W-1:0]  mem_wchk;
    logic              sec_en;
    logic [DATA_W-1:0] sec_data_in;
    logic [CHK_W-1:0]  sec_chk_in;
    logic [DATA_W-1:0] sec_data_out;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wchk,
        output sec_en, sec_data_in, sec_chk_in,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rchk, sec_data_out
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wchk,
        input  sec_en, sec_data_in, sec_chk_in,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rchk, sec_data_out
    );

endinterface

`default_nettype wire

// File: rtl/ecc_scrub_ctrl_addr_gen.sv
//------------------------------------------------------------------------------
// Module : scrub_addr_gen
// Brief  : Scrub window address walker with modulo-2^AW wrap and last flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scrub_addr_gen #(
    parameter int AW = 10
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          i_load,
    input  wire logic [AW-1:0] i_base,
    input  wire logic [AW-1:0] i_last,
    input  wire logic          i_adv,
    output logic [AW-1:0]      o_cur,
    output logic               o_is_last
);

    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_last;

    // Natural AW-bit overflow gives the wrap through 2^AW-1 to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur  <= '0;
            r_last <= '0;
        end else if (i_load) begin
            r_cur  <= i_base;
            r_last <= i_last;
        end else if (i_adv) begin
            r_cur  <= r_cur + AW'(1);
        end
    end

    assign o_cur     = r_cur;
    assign o_is_last = (r_cur == r_last);

endmodule

`default_nettype wire

// File: rtl/ecc_scrub_ctrl.sv
//------------------------------------------------------------------------------
// Module : ecc_scrub_ctrl
// Brief  : Sequential ECC scrub controller driving an external SEC corrector.
//          Optional macro ECC_SCRUB_LOG_EN enables last-error address logging.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          i_start,
    input  wire logic          i_abort,
    input  wire logic [AW-1:0] i_base_addr,
    input  wire logic [AW-1:0] i_last_addr,
    output logic               o_busy,
    output logic               o_done,
    output logic [CW-1:0]      o_err_count,
    output logic [AW-1:0]      o_last_err_addr,
    ecc_scrub_ctrl_if.master   bus
);

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_RD_REQ  = 3'(ST_RD_REQ);
    localparam logic [2:0] S_RD_WAIT = 3'(ST_RD_WAIT);
    localparam logic [2:0] S_CHECK   = 3'(ST_CHECK);
    localparam logic [2:0] S_WR_REQ  = 3'(ST_WR_REQ);
    localparam logic [2:0] S_NEXT    = 3'(ST_NEXT);
    localparam logic [2:0] S_FIN     = 3'(ST_FIN);
    localparam logic [CW-1:0] C_CNT_MAX = '1;

    logic [2:0]        r_state;
    logic              r_abort_pend;
    ecc_word_t         r_raw;
    logic [DATA_W-1:0] r_wdata;
    logic [CHK_W-1:0]  r_wchk;
    logic [CW-1:0]     r_err_cnt;

    logic [AW-1:0]     w_cur;
    logic              w_is_last;
    logic              w_load;
    logic              w_adv;
    logic              w_abort;
    logic              w_corrected;

    assign w_load      = (r_state == S_IDLE) && i_start;
    assign w_abort     = r_abort_pend || i_abort;
    assign w_adv       = (r_state == S_NEXT) && !w_abort && !w_is_last;
    assign w_corrected = (r_state == S_CHECK) && (bus.sec_data_out != r_raw.data);

    scrub_addr_gen #(.AW(AW)) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_base    (i_base_addr),
        .i_last    (i_last_addr),
        .i_adv     (w_adv),
        .o_cur     (w_cur),
        .o_is_last (w_is_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_raw     <= '0;
            r_wdata   <= '0;
            r_wchk    <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_err_cnt <= '0;
                        r_state   <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (w_abort && !bus.mem_gnt) r_state <= S_FIN;
                    else if (bus.mem_gnt)        r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_raw   <= '{data: bus.mem_rdata, chk: bus.mem_rchk};
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_corrected) begin
                        // Stored check bits still describe the true data after a data-bit error.
                        r_wdata <= bus.sec_data_out;
                        r_wchk  <= r_raw.chk;
                        if (r_err_cnt != C_CNT_MAX) r_err_cnt <= r_err_cnt + CW'(1);
                        r_state <= S_WR_REQ;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_WR_REQ: begin
                    if (bus.mem_gnt) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_abort || w_is_last) r_state <= S_FIN;
                    else                      r_state <= S_RD_REQ;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Abort is only meaningful while a pass is running; a start-cycle abort is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_abort_pend <= 1'b0;
        end else if (r_state == S_IDLE || r_state == S_FIN) begin
            r_abort_pend <= 1'b0;
        end else if (i_abort) begin
            r_abort_pend <= 1'b1;
        end
    end

`ifdef ECC_SCRUB_LOG_EN
    logic [AW-1:0] r_last_err_addr;

    always_ff @(posedge clock) begin
        if (reset || w_load) begin
            r_last_err_addr <= '0;
        end else if (w_corrected) begin
            r_last_err_addr <= w_cur;
        end
    end

    assign o_last_err_addr = r_last_err_addr;
`else
    assign o_last_err_addr = '0;
`endif

    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_FIN);
    assign o_err_count     = r_err_cnt;

    assign bus.mem_req     = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign bus.mem_we      = (r_state == S_WR_REQ);
    assign bus.mem_addr    = w_cur;
    assign bus.mem_wdata   = r_wdata;
    assign bus.mem_wchk    = r_wchk;
    assign bus.sec_en      = (r_state == S_CHECK);
    assign bus.sec_data_in = r_raw.data;
    assign bus.sec_chk_in  = r_raw.chk;

endmodule

`default_nettype wire
